// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell stepped LSB-first over WIDTH cycles.
// Optional signed-overflow register is built when SERIAL_ADDER_OVF_EN is defined.

module full_adder (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = x ^ y ^ cin;
   assign cout = (x & y) | (cin & (x ^ y));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             overflow_o
);
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               fa_sum, fa_cout;
   logic               last_step;

   full_adder u_fa (
      .x    (a_sh_q[0]),
      .y    (b_sh_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign last_step = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH-1));

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               a_sh_d  = a_i;
               b_sh_d  = b_i;
               carry_d = cin_i;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // sum bits enter at the MSB so after WIDTH steps bit 0 lands at the LSB
            res_d   = {fa_sum, res_q[WIDTH-1:1]};
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = fa_cout;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_step) begin
               state_d = S_DONE;
               sum_d   = {fa_sum, res_q[WIDTH-1:1]};
               cout_d  = fa_cout;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   assign busy_o = (state_q == S_RUN);
   assign done_o = (state_q == S_DONE);
   assign sum_o  = sum_q;
   assign cout_o = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q, ovf_d;

   // carry_q during the last step is the carry into the MSB
   always_comb begin
      ovf_d = ovf_q;
      if (last_step) ovf_d = carry_q ^ fa_cout;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end

   assign overflow_o = ovf_q;
`else
   assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, random adds vs. arithmetic model, corner sequences.

module tb_serial_adder;
   localparam int W = 8;
`ifdef SERIAL_ADDER_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         start_i;
   logic [W-1:0] a_i, b_i;
   logic         cin_i;
   logic         busy_o, done_o, cout_o, overflow_o;
   logic [W-1:0] sum_o;

   int n_chk  = 0;
   int n_fail = 0;
   logic [W-1:0] prev_sum;
   logic         prev_cout, prev_ovf;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   serial_adder #(.WIDTH(W)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .a_i        (a_i),
      .b_i        (b_i),
      .cin_i      (cin_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .sum_o      (sum_o),
      .cout_o     (cout_o),
      .overflow_o (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer addition plus the two's-complement overflow rule.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        output logic [W-1:0] s, output logic co, output logic ov);
      int unsigned tot;
      tot = int'(a) + int'(b) + int'(cin);
      s   = W'(tot);
      co  = tot[W];
      ov  = OVF_EN & (a[W-1] == b[W-1]) & (s[W-1] != a[W-1]);
   endtask

   task automatic run_add(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] es, input logic ec, input logic eo);
      @(negedge clk_i);
      a_i = a; b_i = b; cin_i = cin; start_i = 1'b1;
      @(posedge clk_i);
      for (int k = 1; k <= W; k++) begin
         @(negedge clk_i);
         if (k == 1) begin
            start_i = 1'b0;
            a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom);
         end
         chk({name, " busy"}, 32'(busy_o), 32'd1);
         chk({name, " done_early"}, 32'(done_o), 32'd0);
         if (k == 1 || k == W) chk({name, " sum_hold"}, 32'(sum_o), 32'(prev_sum));
      end
      @(negedge clk_i);
      chk({name, " done"}, 32'(done_o), 32'd1);
      chk({name, " busy_at_done"}, 32'(busy_o), 32'd0);
      chk({name, " sum"}, 32'(sum_o), 32'(es));
      chk({name, " cout"}, 32'(cout_o), 32'(ec));
      chk({name, " ovf"}, 32'(overflow_o), 32'(eo));
      prev_sum = es; prev_cout = ec; prev_ovf = eo;
      @(negedge clk_i);
      chk({name, " done_pulse"}, 32'(done_o), 32'd0);
   endtask

   initial begin
      vec_t vt[$];
      logic [W-1:0] ms;
      logic         mc, mo;

      vt.push_back('{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0});
      vt.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0});
      vt.push_back('{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0});
      vt.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF_EN});
      vt.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, OVF_EN});
      vt.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
      vt.push_back('{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0});

      // reset held with start asserted
      rst_i = 1'b0; start_i = 1'b1; a_i = 8'hFF; b_i = 8'hFF; cin_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("rst busy", 32'(busy_o), 32'd0);
         chk("rst done", 32'(done_o), 32'd0);
         chk("rst sum", 32'(sum_o), 32'd0);
         chk("rst cout", 32'(cout_o), 32'd0);
         chk("rst ovf", 32'(overflow_o), 32'd0);
      end
      rst_i = 1'b1; start_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         chk("post_rst busy", 32'(busy_o), 32'd0);
         chk("post_rst sum", 32'(sum_o), 32'd0);
      end
      prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;

      foreach (vt[i]) run_add($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin,
                              vt[i].sum, vt[i].cout, vt[i].ovf);

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         logic         rc;
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         model(ra, rb, rc, ms, mc, mo);
         run_add($sformatf("rnd%0d", i), ra, rb, rc, ms, mc, mo);
      end

      // start pulsed while busy must be ignored
      @(negedge clk_i);
      a_i = 8'h03; b_i = 8'h04; cin_i = 1'b0; start_i = 1'b1;
      @(posedge clk_i);
      for (int k = 1; k <= W; k++) begin
         @(negedge clk_i);
         start_i = 1'b0;
         if (k == 3) begin start_i = 1'b1; a_i = 8'hAA; b_i = 8'h55; end
         chk("ign busy", 32'(busy_o), 32'd1);
         chk("ign done_early", 32'(done_o), 32'd0);
         chk("ign sum_hold", 32'(sum_o), 32'(prev_sum));
      end
      start_i = 1'b0;
      @(negedge clk_i);
      chk("ign done", 32'(done_o), 32'd1);
      chk("ign sum", 32'(sum_o), 32'h07);
      chk("ign cout", 32'(cout_o), 32'd0);
      prev_sum = 8'h07;
      for (int k = 0; k < W + 2; k++) begin
         @(negedge clk_i);
         chk("ign no_second", 32'({busy_o, done_o}), 32'd0);
      end

      // abort with reset mid-run
      @(negedge clk_i);
      a_i = 8'h12; b_i = 8'h34; cin_i = 1'b0; start_i = 1'b1;
      @(posedge clk_i);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk_i);
         start_i = 1'b0;
         chk("abort busy", 32'(busy_o), 32'd1);
      end
      rst_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      chk("abort sum", 32'(sum_o), 32'd0);
      chk("abort cout", 32'(cout_o), 32'd0);
      chk("abort ovf", 32'(overflow_o), 32'd0);
      for (int k = 0; k < W + 3; k++) begin
         chk("abort idle", 32'({busy_o, done_o}), 32'd0);
         @(negedge clk_i);
      end
      prev_sum = '0;
      run_add("after_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
